// File: rtl/kanji_font_ctrl_if.sv
// kanji_font_ctrl_if
//   Bus bundle for the Kanji/Hangul font-ROM controller.
//   CPU side : req, wr, rd, port_sel, data_in -> data_out, cpu_wait
//   SDRAM side: mem_req, mem_addr -> mem_ack, mem_data
//   Debug    : fsm_state (0 = IDLE, 1 = FETCH)
//
// Handshake semantics:
//   CPU  - a cycle is accepted at a rising clk edge where req is high and
//          cpu_wait is low. While cpu_wait is high the CPU holds req, rd and
//          port_sel unchanged. Writes never stall.
//   SDRAM- mem_req rises and stays high, with mem_addr stable, until the
//          single-cycle mem_ack strobe; mem_data is valid with mem_ack.
//          At most one request is outstanding.
//
// Modports: slave = the controller, master = the CPU/SDRAM environment.
interface kanji_font_ctrl_if #(
    parameter int PLANES = 2,
    parameter int ADDR_W = 27
);
    localparam int SEL_W = $clog2(PLANES) + 1;

    logic              req;
    logic              wr;
    logic              rd;
    logic [SEL_W-1:0]  port_sel;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              cpu_wait;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;
    logic              fsm_state;

    modport slave (
        input  req, wr, rd, port_sel, data_in, mem_ack, mem_data,
        output data_out, cpu_wait, mem_req, mem_addr, fsm_state
    );

    modport master (
        output req, wr, rd, port_sel, data_in, mem_ack, mem_data,
        input  data_out, cpu_wait, mem_req, mem_addr, fsm_state
    );
endinterface

// File: rtl/kanji_font_ctrl.sv
// kanji_font_ctrl
//   Font-ROM controller with PLANES independent glyph-address channels.
//   Each channel keeps a 17-bit offset and a one-byte prefetch buffer that is
//   refilled from SDRAM after every address write or data-port read, so the
//   CPU normally reads the data port without wait states.
//
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset
//   hangul   - Hangul addressing mode (only with KANJI_HANGUL_EN)
//   ram_base - font image base address in SDRAM
//   ram_size - image size in 16 KB units
//   bus      - kanji_font_ctrl_if.slave (CPU port, SDRAM port, debug state)
//
// Optional feature macro: KANJI_HANGUL_EN
//   When defined, planes >= 1 in Hangul mode take a 7-bit column field
//   (off[11:5]) and a 5-bit row field (off[16:12]).
module kanji_font_ctrl #(
    parameter int PLANES = 2,
    parameter int ADDR_W = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hangul,
    input  logic [ADDR_W-1:0] ram_base,
    input  logic [7:0]        ram_size,
    kanji_font_ctrl_if.slave  bus
);
    localparam int PIDX_W = (PLANES > 1) ? $clog2(PLANES) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PIDX_W-1:0] tag_q, tag_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [16:0]       off_q   [PLANES];
    logic [16:0]       off_d   [PLANES];
    logic [7:0]        glyph_q [PLANES];
    logic [7:0]        glyph_d [PLANES];
    logic [PLANES-1:0] valid_q, valid_d;
    logic [PLANES-1:0] pending_q, pending_d;

    // CPU decode
    logic [PIDX_W-1:0] sel_p;
    logic              sel_hi;
    logic              sel_ok;
    logic              cpu_wr;
    logic              cpu_rd;
    logic              sel_valid;
    logic              hangul_wide;

    assign sel_p     = PIDX_W'(bus.port_sel >> 1);
    assign sel_hi    = bus.port_sel[0];
    assign sel_ok    = (int'(sel_p) < PLANES);
    assign cpu_wr    = bus.req & bus.wr & sel_ok;
    assign cpu_rd    = bus.req & bus.rd & ~bus.wr & sel_ok;
    assign sel_valid = valid_q[sel_p];

`ifdef KANJI_HANGUL_EN
    assign hangul_wide = hangul & (sel_p != '0);
`else
    logic unused_hangul;
    assign unused_hangul = hangul;
    assign hangul_wide   = 1'b0;
`endif

    assign bus.cpu_wait  = cpu_rd & sel_hi & ~sel_valid;
    assign bus.data_out  = (cpu_rd & sel_hi & sel_valid) ? glyph_q[sel_p] : 8'hFF;
    assign bus.mem_req   = (state_q == ST_FETCH);
    assign bus.mem_addr  = addr_q;
    assign bus.fsm_state = state_q;

    // A plane is backed by SDRAM only if the image covers its 128 KB window.
    logic [PLANES-1:0] fetchable;
    always_comb begin
        for (int i = 0; i < PLANES; i++) begin
            fetchable[i] = (32'(ram_size) >= 32'(8 * (i + 1)));
        end
    end

    // Lowest-index fetchable plane with a pending refill.
    logic              found;
    logic [PIDX_W-1:0] launch_p;
    always_comb begin
        found    = 1'b0;
        launch_p = '0;
        for (int i = PLANES - 1; i >= 0; i--) begin
            if (pending_q[i] && fetchable[i]) begin
                found    = 1'b1;
                launch_p = PIDX_W'(i);
            end
        end
    end

    // Physical address of the plane about to be launched.
    logic [ADDR_W-1:0] plane0_mask;
    logic [ADDR_W-1:0] rel_addr;
    always_comb begin
        plane0_mask = (ADDR_W'(ram_size) << 14) - ADDR_W'(1);
        rel_addr    = (ADDR_W'(launch_p) << 17) | ADDR_W'(off_q[launch_p]);
        if (launch_p == '0) begin
            rel_addr = rel_addr & plane0_mask;
        end
    end

    // A write that hits the plane whose fetch is in flight, or is being
    // launched this very cycle, makes the returning byte stale.
    logic              in_flight;
    logic [PIDX_W-1:0] busy_p;
    logic              hit_busy;
    assign in_flight = (state_q == ST_FETCH) | found;
    assign busy_p    = (state_q == ST_FETCH) ? tag_q : launch_p;
    assign hit_busy  = cpu_wr & in_flight & (sel_p == busy_p);

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        discard_d = discard_q;
        addr_d    = addr_q;
        off_d     = off_q;
        glyph_d   = glyph_q;
        valid_d   = valid_q;
        pending_d = pending_q;

        // Planes with no SDRAM behind them read as blank (0xFF).
        for (int i = 0; i < PLANES; i++) begin
            if (pending_q[i] && !fetchable[i]) begin
                glyph_d[i]   = 8'hFF;
                valid_d[i]   = 1'b1;
                pending_d[i] = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    pending_d[launch_p] = 1'b0;
                    tag_d               = launch_p;
                    addr_d              = ram_base + rel_addr;
                    discard_d           = 1'b0;
                    state_d             = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    if (!discard_q && !hit_busy) begin
                        glyph_d[tag_q] = bus.mem_data;
                        valid_d[tag_q] = 1'b1;
                    end
                    discard_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU accesses come last so they override fetch-side updates.
        if (cpu_wr) begin
            if (!sel_hi) begin
                if (hangul_wide) off_d[sel_p][11:5] = bus.data_in[6:0];
                else             off_d[sel_p][10:5] = bus.data_in[5:0];
            end else begin
                if (hangul_wide) off_d[sel_p][16:12] = bus.data_in[5:1];
                else             off_d[sel_p][16:11] = bus.data_in[5:0];
            end
            off_d[sel_p][4:0] = 5'd0;
            valid_d[sel_p]    = 1'b0;
            pending_d[sel_p]  = 1'b1;
            // If the ack lands in the same cycle it is dropped directly above,
            // so discard must not leak into the next fetch.
            if (hit_busy && !((state_q == ST_FETCH) && bus.mem_ack)) begin
                discard_d = 1'b1;
            end
        end else if (cpu_rd && sel_hi && sel_valid) begin
            // Consume the byte and prefetch the next one within the glyph row.
            valid_d[sel_p]    = 1'b0;
            off_d[sel_p][4:0] = off_q[sel_p][4:0] + 5'd1;
            pending_d[sel_p]  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tag_q     <= '0;
            discard_q <= 1'b0;
            addr_q    <= '0;
            valid_q   <= '0;
            pending_q <= '0;
            for (int i = 0; i < PLANES; i++) begin
                off_q[i]   <= 17'd0;
                glyph_q[i] <= 8'hFF;
            end
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            discard_q <= discard_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            off_q     <= off_d;
            glyph_q   <= glyph_d;
        end
    end
endmodule
